// File: rtl/mult_pipe_if.sv
// Signals between the issue stage, branch resolution, the CDB and mult_pipe.
// The RS/CDB side drives through master; the multiplier connects through slave.
interface mult_pipe_if #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 6,
  parameter int BMASK_W = 4
);
  logic               issue_valid;
  logic [1:0]         issue_func;
  logic [XLEN-1:0]    issue_rs1;
  logic [XLEN-1:0]    issue_rs2;
  logic [TAG_W-1:0]   issue_tag;
  logic [BMASK_W-1:0] issue_bmask;
  logic               br_valid;
  logic               br_mispredict;
  logic [BMASK_W-1:0] br_tag;
  logic               cdb_stall;
  logic               busy;
  logic [TAG_W-1:0]   early_mult_tag;
  logic               done_valid;
  logic [TAG_W-1:0]   done_tag;
  logic [XLEN-1:0]    done_result;
  logic [BMASK_W-1:0] done_bmask;

  modport master (
    output issue_valid, issue_func, issue_rs1, issue_rs2, issue_tag, issue_bmask,
    output br_valid, br_mispredict, br_tag, cdb_stall,
    input  busy, early_mult_tag, done_valid, done_tag, done_result, done_bmask
  );

  modport slave (
    input  issue_valid, issue_func, issue_rs1, issue_rs2, issue_tag, issue_bmask,
    input  br_valid, br_mispredict, br_tag, cdb_stall,
    output busy, early_mult_tag, done_valid, done_tag, done_result, done_bmask
  );
endinterface

// File: rtl/mult_pipe.sv
// Pipelined integer multiplier: each stage folds one multiplier chunk into a 2*XLEN
// partial sum; entries carry a branch mask so mispredicts can squash them anywhere.
module mult_pipe #(
  parameter int XLEN    = 32,
  parameter int STAGES  = 4,
  parameter int TAG_W   = 6,
  parameter int BMASK_W = 4
) (
  input  logic       clock,
  input  logic       reset,
  mult_pipe_if.slave bus
);
  localparam int W2 = 2 * XLEN;
  localparam int CW = W2 / STAGES;

  if (STAGES < 2 || (W2 % STAGES) != 0) begin : g_bad_stages
    $error("mult_pipe: STAGES must be at least 2 and divide 2*XLEN");
  end

  typedef enum logic [1:0] {
    FN_MUL    = 2'd0,
    FN_MULH   = 2'd1,
    FN_MULHSU = 2'd2,
    FN_MULHU  = 2'd3
  } func_e;

  typedef struct packed {
    logic               valid;
    logic [TAG_W-1:0]   tag;
    logic [BMASK_W-1:0] bmask;
    func_e              func;
    logic [W2-1:0]      mcand;   // multiplicand, pre-shifted to the current chunk position
    logic [W2-1:0]      mplier;  // multiplier, low CW bits are the next chunk to add
    logic [W2-1:0]      sum;
  } entry_t;

  typedef struct packed {
    logic               valid;
    logic [TAG_W-1:0]   tag;
    logic [BMASK_W-1:0] bmask;
    logic [XLEN-1:0]    result;
  } out_t;

  // Applies this cycle's branch resolution to one entry; dead entries read as tag 0.
  function automatic entry_t resolve(entry_t e, logic squash, logic clear,
                                     logic [BMASK_W-1:0] br);
    entry_t r = e;
    if (clear) r.bmask = e.bmask & ~br;
    if (squash && (e.bmask & br) != '0) r.valid = 1'b0;
    if (!r.valid) begin
      r.tag   = '0;
      r.bmask = '0;
    end
    return r;
  endfunction

  function automatic entry_t step(entry_t e);
    entry_t r = e;
    r.sum    = e.sum + e.mcand * W2'(e.mplier[CW-1:0]);
    r.mcand  = e.mcand << CW;
    r.mplier = e.mplier >> CW;
    return r;
  endfunction

  entry_t stage_q [1:STAGES-1];
  out_t   out_q;

  entry_t cur [0:STAGES-1];  // each stage as seen after branch resolution (0 = issue)
  entry_t nxt [1:STAGES];    // what each stage loads when the pipe advances
  out_t   out_cur;
  out_t   out_adv;
  logic   squash;
  logic   clear;
  logic   stall;

  assign squash = bus.br_valid & bus.br_mispredict;
  assign clear  = bus.br_valid & ~bus.br_mispredict;
  assign stall  = out_q.valid & bus.cdb_stall;

  // NOTE: every variable driven here gets a value on every pass, so no latch can form.
  always_comb begin
    entry_t issue_e;
    func_e  fn;
    logic   sext1;
    logic   sext2;
    fn      = func_e'(bus.issue_func);
    sext1   = (fn == FN_MULH) || (fn == FN_MULHSU);
    sext2   = (fn == FN_MULH);
    issue_e = '{
      valid:  bus.issue_valid & ~stall,
      tag:    bus.issue_tag,
      bmask:  bus.issue_bmask,
      func:   fn,
      mcand:  {{XLEN{bus.issue_rs1[XLEN-1] & sext1}}, bus.issue_rs1},
      mplier: {{XLEN{bus.issue_rs2[XLEN-1] & sext2}}, bus.issue_rs2},
      sum:    '0
    };
    cur[0] = resolve(issue_e, squash, clear, bus.br_tag);
    for (int k = 1; k < STAGES; k++) begin
      cur[k] = resolve(stage_q[k], squash, clear, bus.br_tag);
    end
    for (int k = 1; k <= STAGES; k++) begin
      nxt[k] = step(cur[k-1]);
    end

    out_adv.valid  = nxt[STAGES].valid;
    out_adv.tag    = nxt[STAGES].tag;
    out_adv.bmask  = nxt[STAGES].bmask;
    out_adv.result = !nxt[STAGES].valid       ? '0 :
                     (nxt[STAGES].func == FN_MUL) ? nxt[STAGES].sum[XLEN-1:0]
                                                  : nxt[STAGES].sum[W2-1:XLEN];

    // A stalled result still sees branch resolution.
    out_cur = out_q;
    if (clear) out_cur.bmask = out_q.bmask & ~bus.br_tag;
    if (squash && (out_q.bmask & bus.br_tag) != '0) out_cur = '0;
  end

  // NOTE: state registers use non-blocking assignments so all stages shift off the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k < STAGES; k++) stage_q[k] <= '0;
      out_q <= '0;
    end else if (stall) begin
      for (int k = 1; k < STAGES; k++) stage_q[k] <= cur[k];
      out_q <= out_cur;
    end else begin
      for (int k = 1; k < STAGES; k++) stage_q[k] <= nxt[k];
      out_q <= out_adv;
    end
  end

  assign bus.busy           = stall;
  assign bus.early_mult_tag = (cur[STAGES-1].valid && !stall) ? cur[STAGES-1].tag : '0;
  assign bus.done_valid     = out_q.valid;
  assign bus.done_tag       = out_q.tag;
  assign bus.done_result    = out_q.result;
  assign bus.done_bmask     = out_q.bmask;
endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: directed cases plus random traffic against a
// model that computes each product at issue and just tracks where it sits in time.
module tb_mult_pipe;
  localparam int XLEN = 32;
  localparam int S    = 4;
  localparam int TW   = 6;
  localparam int BW   = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  mult_pipe_if #(.XLEN(XLEN), .TAG_W(TW), .BMASK_W(BW)) bus ();

  mult_pipe #(.XLEN(XLEN), .STAGES(S), .TAG_W(TW), .BMASK_W(BW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit            v;
    bit [TW-1:0]   tag;
    bit [BW-1:0]   bm;
    bit [XLEN-1:0] res;
  } ent_t;

  ent_t pipe [1:S];  // pipe[S] is the entry currently presented as done

  function automatic logic [31:0] ref_mul(logic [1:0] f, logic [31:0] a, logic [31:0] b);
    longint     sa = longint'($signed(a));
    longint     sb = longint'($signed(b));
    longint     ub = longint'({32'b0, b});
    logic [63:0] p;
    case (f)
      2'd1:    p = sa * sb;
      2'd2:    p = sa * ub;
      default: p = {32'b0, a} * {32'b0, b};
    endcase
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic bit killed(bit [BW-1:0] bm);
    return bus.br_valid && bus.br_mispredict && ((bm & bus.br_tag) != '0);
  endfunction

  task automatic model_reset();
    for (int k = 1; k <= S; k++) pipe[k] = '{default: 0};
  endtask

  task automatic compare_all();
    bit          exp_busy;
    bit [TW-1:0] exp_early;
    exp_busy  = pipe[S].v && bus.cdb_stall;
    exp_early = (pipe[S-1].v && !exp_busy && !killed(pipe[S-1].bm)) ? pipe[S-1].tag : '0;
    chk("busy", bus.busy, exp_busy);
    chk("early_mult_tag", bus.early_mult_tag, exp_early);
    chk("done_valid", bus.done_valid, pipe[S].v);
    chk("done_tag", bus.done_tag, pipe[S].tag);
    if (pipe[S].v) begin
      chk("done_result", bus.done_result, pipe[S].res);
      chk("done_bmask", bus.done_bmask, pipe[S].bm);
    end
  endtask

  task automatic model_step();
    ent_t inc;
    bit   busy_m;
    bit   cl;
    if (!reset) begin
      model_reset();
      return;
    end
    busy_m = pipe[S].v && bus.cdb_stall;
    cl     = bus.br_valid && !bus.br_mispredict;
    for (int k = 1; k <= S; k++) begin
      if (killed(pipe[k].bm)) pipe[k] = '{default: 0};
      else if (cl)            pipe[k].bm = pipe[k].bm & ~bus.br_tag;
    end
    inc = '{default: 0};
    if (bus.issue_valid && !busy_m && !killed(bus.issue_bmask)) begin
      inc.v   = 1'b1;
      inc.tag = bus.issue_tag;
      inc.bm  = cl ? (bus.issue_bmask & ~bus.br_tag) : bus.issue_bmask;
      inc.res = ref_mul(bus.issue_func, bus.issue_rs1, bus.issue_rs2);
    end
    if (!busy_m) begin
      for (int k = S; k > 1; k--) pipe[k] = pipe[k-1];
      pipe[1] = inc;
    end
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model on the edge, then
  // return just after the edge so the caller can drive the next cycle's inputs.
  task automatic tick();
    @(negedge clock);
    compare_all();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle();
    bus.issue_valid   = 1'b0;
    bus.issue_func    = 2'd0;
    bus.issue_rs1     = '0;
    bus.issue_rs2     = '0;
    bus.issue_tag     = '0;
    bus.issue_bmask   = '0;
    bus.br_valid      = 1'b0;
    bus.br_mispredict = 1'b0;
    bus.br_tag        = '0;
    bus.cdb_stall     = 1'b0;
  endtask

  task automatic do_issue(logic [1:0] f, logic [31:0] a, logic [31:0] b,
                          logic [TW-1:0] tag, logic [BW-1:0] bm);
    bus.issue_valid = 1'b1;
    bus.issue_func  = f;
    bus.issue_rs1   = a;
    bus.issue_rs2   = b;
    bus.issue_tag   = tag;
    bus.issue_bmask = bm;
  endtask

  task automatic branch(logic mis, logic [BW-1:0] id);
    bus.br_valid      = 1'b1;
    bus.br_mispredict = mis;
    bus.br_tag        = id;
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    idle();
    model_reset();
    tick();
    tick();
    chk("rst_done_valid", bus.done_valid, 1'b0);
    chk("rst_done_tag", bus.done_tag, '0);
    chk("rst_done_result", bus.done_result, '0);
    chk("rst_done_bmask", bus.done_bmask, '0);
    chk("rst_early", bus.early_mult_tag, '0);
    chk("rst_busy", bus.busy, 1'b0);
    reset = 1'b1;
    tick();

    // Single MUL with fixed latency checkpoints.
    do_issue(2'd0, 32'd7, 32'hFFFF_FFFD, 6'd5, 4'b0000);
    tick();
    idle();
    tick();
    tick();
    chk("mul_early_c3", bus.early_mult_tag, 6'd5);
    chk("mul_valid_c3", bus.done_valid, 1'b0);
    tick();
    chk("mul_valid_c4", bus.done_valid, 1'b1);
    chk("mul_result_c4", bus.done_result, 32'hFFFF_FFEB);
    chk("mul_tag_c4", bus.done_tag, 6'd5);
    tick();
    chk("mul_valid_c5", bus.done_valid, 1'b0);

    // High-half variants with sign corners.
    do_issue(2'd1, 32'h8000_0000, 32'h8000_0000, 6'd10, 4'b0000);
    tick();
    do_issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd11, 4'b0000);
    tick();
    do_issue(2'd2, 32'hFFFF_FFFF, 32'd2, 6'd12, 4'b0000);
    tick();
    idle();
    tick();
    chk("mulh_result", bus.done_result, 32'h4000_0000);
    tick();
    chk("mulhu_result", bus.done_result, 32'hFFFF_FFFE);
    tick();
    chk("mulhsu_result", bus.done_result, 32'hFFFF_FFFF);
    drain(2);

    // Four back-to-back issues, tags 1..4.
    for (int i = 1; i <= 4; i++) begin
      do_issue(2'($urandom_range(0, 3)), $urandom, $urandom, 6'(i), 4'b0000);
      tick();
    end
    idle();
    drain(6);

    // Two-cycle CDB stall with tag 1 done and tag 2 right behind it.
    do_issue(2'd0, $urandom, $urandom, 6'd1, 4'b0000);
    tick();
    do_issue(2'd3, $urandom, $urandom, 6'd2, 4'b0000);
    tick();
    idle();
    tick();
    tick();
    bus.cdb_stall = 1'b1;
    #1;
    chk("stall_busy", bus.busy, 1'b1);
    chk("stall_early", bus.early_mult_tag, '0);
    tick();
    chk("stall_hold_tag", bus.done_tag, 6'd1);
    tick();
    bus.cdb_stall = 1'b0;
    #1;
    chk("stall_end_tag", bus.done_tag, 6'd1);
    tick();
    chk("after_stall_tag", bus.done_tag, 6'd2);
    chk("after_stall_valid", bus.done_valid, 1'b1);
    drain(3);

    // Correct resolution of 0010, then mispredict of 0001.
    do_issue(2'd0, $urandom, $urandom, 6'd3, 4'b0001);
    tick();
    do_issue(2'd0, $urandom, $urandom, 6'd4, 4'b0010);
    tick();
    idle();
    branch(1'b0, 4'b0010);
    tick();
    idle();
    branch(1'b1, 4'b0001);
    #1;
    chk("squash_early", bus.early_mult_tag, '0);
    tick();
    idle();
    chk("squash_no_done", bus.done_valid, 1'b0);
    tick();
    chk("survivor_tag", bus.done_tag, 6'd4);
    chk("survivor_bmask", bus.done_bmask, 4'b0000);
    drain(2);

    // Issue killed on arrival by a mispredict in the same cycle.
    do_issue(2'd0, $urandom, $urandom, 6'd9, 4'b0100);
    branch(1'b1, 4'b0100);
    tick();
    idle();
    drain(5);

    // Stall and squash of the output entry in the same cycle.
    do_issue(2'd0, $urandom, $urandom, 6'd7, 4'b1000);
    tick();
    idle();
    drain(3);
    bus.cdb_stall = 1'b1;
    tick();
    branch(1'b1, 4'b1000);
    #1;
    chk("stall_squash_busy", bus.busy, 1'b1);
    tick();
    bus.br_valid = 1'b0;
    #1;
    chk("stall_squash_valid", bus.done_valid, 1'b0);
    chk("stall_squash_busy_falls", bus.busy, 1'b0);
    idle();
    drain(2);

    // Random traffic with branches and stalls.
    for (int i = 0; i < 400; i++) begin
      idle();
      if ($urandom_range(0, 3) != 0) begin
        do_issue(2'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom,
                 ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom,
                 6'($urandom_range(0, 63)), 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
      end
      if ($urandom_range(0, 5) == 0) branch(1'($urandom_range(0, 1)), 4'(1 << $urandom_range(0, 3)));
      bus.cdb_stall = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle();
    drain(6);

    // Reset pulled mid-flight, released a cycle later.
    do_issue(2'd1, $urandom, $urandom, 6'd21, 4'b0000);
    tick();
    do_issue(2'd0, $urandom, $urandom, 6'd22, 4'b0000);
    tick();
    idle();
    reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_done_valid", bus.done_valid, 1'b0);
    chk("midrst_done_tag", bus.done_tag, '0);
    chk("midrst_done_result", bus.done_result, '0);
    chk("midrst_early", bus.early_mult_tag, '0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_no_done", bus.done_valid, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mult_pipe.md
Name: mult_pipe

Overview:
- Pipelined integer multiply unit directly downstream of the issue stage.
- Accepts multiply instructions that issue from the ALU/mult RS port, together with their operand values read from the physical regfile.
- Produces a completed result for CDB arbitration.
- Drives `early_mult_tag` one cycle ahead of completion so the RS can wake up dependents and hold ALU issue off that writeback slot.

Parameters:
- XLEN, 32, operand/result width.
- STAGES, 4, pipeline depth (issue-to-done latency in cycles); must divide 2*XLEN, minimum 2.
- TAG_W, 6, physical register tag width ($clog2(PHYS_REGFILE_SIZE)).
- BMASK_W, 4, branch mask width (one bit per in-flight branch).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- issue_valid  in  1  mult instruction presented this cycle.
- issue_func  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- issue_rs1  in  XLEN  operand A.
- issue_rs2  in  XLEN  operand B.
- issue_tag  in  TAG_W  destination physical tag.
- issue_bmask  in  BMASK_W  branches this instruction depends on.
- br_valid  in  1  a branch resolves this cycle.
- br_mispredict  in  1  the resolving branch was mispredicted.
- br_tag  in  BMASK_W  one-hot ID of the resolving branch.
- cdb_stall  in  1  CDB did not accept `done` this cycle.
- busy  out  1  pipeline frozen; issue not accepted this cycle.
- early_mult_tag  out  TAG_W  tag completing next cycle, 0 if none.
- done_valid  out  1  result valid.
- done_tag  out  TAG_W  tag of the result.
- done_result  out  XLEN  result value.
- done_bmask  out  BMASK_W  current branch mask of the result.

Behaviour:
- Reset (reset=0, asynchronous):
  - Clear every stage valid bit, mask and tag.
  - `done_valid`=0, `done_tag`=0, `done_result`=0, `done_bmask`=0, `early_mult_tag`=0, `busy`=0.
  - Reset asserted mid-operation drops all in-flight work; no partial result is ever emitted after release.
- Pipeline structure:
  - Stage registers S1..S(STAGES-1) plus the output register. The output register is stage STAGES.
  - Each stage holds valid, tag, bmask, func, extended operands, partial sum and a shifted multiplier.
- Operand extension to 2*XLEN:
  - rs1 is sign-extended for MULH and MULHSU, otherwise zero-extended.
  - rs2 is sign-extended for MULH only.
- Arithmetic:
  - Each stage adds the product of the multiplicand with the next (2*XLEN/STAGES)-bit multiplier chunk, shifted into place.
  - The sum is mod 2^(2*XLEN).
  - Result for MUL is product[XLEN-1:0]; for all other funcs it is product[2*XLEN-1:XLEN].
- Latency: an instruction accepted at edge t (`issue_valid`=1, `busy`=0) shows `done_valid`=1 after edge t+STAGES-1, i.e. STAGES cycles after it was presented.
- Throughput: one instruction per cycle when not stalled.
- Stall:
  - `busy` = `done_valid` & `cdb_stall` (combinational).
  - While busy, every stage holds its contents.
  - `issue_valid` while busy is a protocol violation; the block ignores the instruction.
- Bubbles: when not busy, everything advances each cycle. A stage with no valid predecessor becomes invalid, with tag 0.
- `early_mult_tag`:
  - Equals the tag of stage STAGES-1 when that stage is valid, `busy`=0, and the entry is not killed this cycle.
  - Otherwise 0.
  - An instruction with destination tag 0 therefore never raises the early tag.
- Branch resolution (applied to every stage, including the output register and the incoming issue):
  - Mispredict (`br_valid` & `br_mispredict`): any entry with (bmask & `br_tag`)!=0 is invalidated at the next edge. A killed output entry deasserts `done_valid` next cycle even if stalled.
  - Correct prediction (`br_valid` & ~`br_mispredict`): clear the `br_tag` bit from every entry's bmask, the incoming issue included.
  - Resolution acts whether or not the pipeline is stalled.
- Simultaneous events:
  - Issue plus mispredict hitting the issue's mask: the instruction is not accepted.
  - Stall plus squash of the output entry: the output is invalidated and `busy` falls the following cycle.

Test Plan:
- Single MUL, rs1=7, rs2=0xFFFFFFFD, tag=5, at cycle 0 -> `early_mult_tag`=5 at cycle 3, `done_valid`=1 with `done_result`=0xFFFFFFEB and `done_tag`=5 at cycle 4, then `done_valid`=0.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- Four back-to-back issues, tags 1..4 -> `done_valid` held for cycles 4..7 with tags 1,2,3,4 in order; `early_mult_tag` 1..4 on cycles 3..6.
- `cdb_stall`=1 for 2 cycles while tag 1 is done and tag 2 is behind it -> `busy`=1 during the stall, `done_tag`=1 held, `early_mult_tag`=0; tag 2 is done 1 cycle after the stall ends, with no loss or duplication.
- In-flight tags 3 (bmask 0001) and 4 (bmask 0010); `br_valid`=1, `br_mispredict`=1, `br_tag`=0001 -> tag 3 never completes, tag 4 completes on time; a prior correct resolution of 0010 makes `done_bmask` of tag 4 equal 0000.
- Reset pulled low 2 cycles after an issue, released 1 cycle later -> all outputs 0 immediately; no `done_valid` on any later cycle.
